// File: rtl/manchester_tx.sv
// Sampled-Manchester transmitter: 24-sample sync, 16 data bits, 1 odd-parity bit, 8 samples per bit.
// Define TX_PARITY_INJECT_EN to add the inject_perr port, which inverts a frame's parity bit.
module manchester_tx (
    input  logic        clk_8M,
    input  logic        clrn,
    input  logic [15:0] word_in,
    input  logic [1:0]  word_type,
    input  logic        load,
`ifdef TX_PARITY_INJECT_EN
    input  logic        inject_perr,
`endif
    output logic        ready,
    output logic        data_out,
    output logic        tx_active,
    output logic        done,
    output logic        type_err
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_samp, w_samp_nxt;
    logic [3:0]  r_bit, w_bit_nxt;
    logic [15:0] r_word, w_word_nxt;
    logic [1:0]  r_type, w_type_nxt;
    logic        r_perr, w_perr_nxt;
    logic        r_ready, r_data_out, r_tx_active, r_done, r_type_err;
    logic        w_inj, w_accept, w_valid, w_start;
    logic        w_dout_nxt, w_done_nxt;

`ifdef TX_PARITY_INJECT_EN
    assign w_inj = inject_perr;
`else
    assign w_inj = 1'b0;
`endif

    assign w_accept = load & r_ready;
    assign w_valid  = (word_type == 2'b01) || (word_type == 2'b10);
    assign w_start  = w_accept & w_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_samp_nxt  = r_samp;
        w_bit_nxt   = r_bit;
        w_word_nxt  = r_word;
        w_type_nxt  = r_type;
        w_perr_nxt  = r_perr;
        case (r_state)
            S_SYNC: begin
                if (r_samp == 5'd23) begin
                    w_state_nxt = S_DATA;
                    w_samp_nxt  = 5'd0;
                end else begin
                    w_samp_nxt = r_samp + 5'd1;
                end
            end
            S_DATA: begin
                if (r_samp == 5'd7) begin
                    w_samp_nxt = 5'd0;
                    if (r_bit == 4'd15) begin
                        w_state_nxt = S_PARITY;
                        w_bit_nxt   = 4'd0;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end else begin
                    w_samp_nxt = r_samp + 5'd1;
                end
            end
            S_PARITY: begin
                if (r_samp == 5'd7) begin
                    w_state_nxt = S_IDLE;
                    w_samp_nxt  = 5'd0;
                end else begin
                    w_samp_nxt = r_samp + 5'd1;
                end
            end
            default: ;
        endcase
        // A start is only possible while ready, i.e. in IDLE or the last parity sample.
        if (w_start) begin
            w_state_nxt = S_SYNC;
            w_samp_nxt  = 5'd0;
            w_bit_nxt   = 4'd0;
            w_word_nxt  = word_in;
            w_type_nxt  = word_type;
            w_perr_nxt  = w_inj;
        end
    end

    // Outputs are decoded from the next state so each sample lands on the edge that enters it.
    always_comb begin
        w_dout_nxt = 1'b0;
        case (w_state_nxt)
            S_SYNC:   w_dout_nxt = (w_type_nxt == 2'b10) ^ (w_samp_nxt >= 5'd12);
            S_DATA:   w_dout_nxt = w_word_nxt[4'd15 - w_bit_nxt] ^ w_samp_nxt[2];
            S_PARITY: w_dout_nxt = (~^w_word_nxt) ^ w_perr_nxt ^ w_samp_nxt[2];
            default:  w_dout_nxt = 1'b0;
        endcase
        w_done_nxt = (w_state_nxt == S_PARITY) && (w_samp_nxt == 5'd7);
    end

    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_samp      <= 5'd0;
            r_bit       <= 4'd0;
            r_word      <= 16'd0;
            r_type      <= 2'd0;
            r_perr      <= 1'b0;
            r_ready     <= 1'b1;
            r_data_out  <= 1'b0;
            r_tx_active <= 1'b0;
            r_done      <= 1'b0;
            r_type_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_samp      <= w_samp_nxt;
            r_bit       <= w_bit_nxt;
            r_word      <= w_word_nxt;
            r_type      <= w_type_nxt;
            r_perr      <= w_perr_nxt;
            r_ready     <= (w_state_nxt == S_IDLE) || w_done_nxt;
            r_data_out  <= w_dout_nxt;
            r_tx_active <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_type_err  <= w_accept & ~w_valid;
        end
    end

    assign ready     = r_ready;
    assign data_out  = r_data_out;
    assign tx_active = r_tx_active;
    assign done      = r_done;
    assign type_err  = r_type_err;

endmodule
